// File: rtl/output_queue_scheduler_if.sv
// Bundle of the enqueue, shared-buffer read and packet-output signals of output_queue_scheduler.
// The master side drives enqueues, port permissions and buffer read data; the slave is the scheduler.
interface output_queue_scheduler_if #(
  parameter int NUM_PORTS                   = 4,
  parameter int PORT_BITWIDTH               = 2,
  parameter int SHARED_BUFFER_ADDR_BITWIDTH = 13,
  parameter int PACKET_DATA_BITWIDTH        = 64
) ();
  logic                                   enq_valid;
  logic [PORT_BITWIDTH-1:0]               enq_port;
  logic [SHARED_BUFFER_ADDR_BITWIDTH-1:0] enq_addr;
  logic                                   enq_ready;
  logic [NUM_PORTS-1:0]                   port_ready;
  logic                                   sb_rd_req;
  logic [SHARED_BUFFER_ADDR_BITWIDTH-1:0] sb_ip;
  logic [PACKET_DATA_BITWIDTH-1:0]        sb_odata;
  logic                                   sb_packet_read_done;
  logic                                   out_valid;
  logic [PORT_BITWIDTH-1:0]               out_port;
  logic [PACKET_DATA_BITWIDTH-1:0]        out_data;
  logic                                   out_sop;
  logic                                   out_eop;
  logic [NUM_PORTS-1:0]                   queue_empty;
  logic [NUM_PORTS-1:0]                   queue_full;

  modport master (
    output enq_valid, enq_port, enq_addr, port_ready, sb_odata, sb_packet_read_done,
    input  enq_ready, sb_rd_req, sb_ip, out_valid, out_port, out_data, out_sop, out_eop,
           queue_empty, queue_full
  );

  modport slave (
    input  enq_valid, enq_port, enq_addr, port_ready, sb_odata, sb_packet_read_done,
    output enq_ready, sb_rd_req, sb_ip, out_valid, out_port, out_data, out_sop, out_eop,
           queue_empty, queue_full
  );
endinterface

// File: rtl/output_queue_scheduler.sv
// Per-port FIFOs of packet head addresses, round-robin port selection, and streaming of the
// linked-list packet words read from the shared buffer out to the granted port.
module output_queue_scheduler #(
  parameter int NUM_PORTS                   = 4,
  parameter int PORT_BITWIDTH               = 2,
  parameter int SHARED_BUFFER_ADDR_BITWIDTH = 13,
  parameter int PACKET_DATA_BITWIDTH        = 64,
  parameter int QUEUE_DEPTH_BITWIDTH        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output_queue_scheduler_if.slave bus
);
  localparam int DEPTH = 1 << QUEUE_DEPTH_BITWIDTH;

  typedef logic [SHARED_BUFFER_ADDR_BITWIDTH-1:0] addr_t;
  typedef logic [QUEUE_DEPTH_BITWIDTH-1:0]        ptr_t;
  typedef logic [QUEUE_DEPTH_BITWIDTH:0]          cnt_t;
  typedef logic [PORT_BITWIDTH-1:0]               port_t;
  typedef logic [PACKET_DATA_BITWIDTH-1:0]        data_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_e;

  state_e               state_q, state_d;
  addr_t                mem_q [NUM_PORTS][DEPTH];
  ptr_t                 wr_ptr_q [NUM_PORTS];
  ptr_t                 wr_ptr_d [NUM_PORTS];
  ptr_t                 rd_ptr_q [NUM_PORTS];
  ptr_t                 rd_ptr_d [NUM_PORTS];
  cnt_t                 cnt_q [NUM_PORTS];
  cnt_t                 cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty_q, empty_d;
  logic [NUM_PORTS-1:0] full_q, full_d;
  port_t                last_grant_q, last_grant_d;
  addr_t                sb_ip_q, sb_ip_d;
  port_t                out_port_q, out_port_d;
  data_t                out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic                 first_q, first_d;

  logic                 enq_ready;
  logic                 enq_fire;
  logic                 pop;
  logic                 sb_rd_req;
  logic                 grant_found;
  port_t                grant_port;
  port_t                cand;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] push_vec;
  logic [NUM_PORTS-1:0] pop_vec;

  // Readiness comes from the registered full flag, so a pop in the same cycle never frees a slot early.
  assign enq_ready = !full_q[bus.enq_port];
  assign enq_fire  = bus.enq_valid && enq_ready;
  assign eligible  = ~empty_q & bus.port_ready;

  // First eligible port after the last grant, wrapping modulo NUM_PORTS.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_port  = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = port_t'((int'(last_grant_q) + i) % NUM_PORTS);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_port  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    sb_rd_req    = 1'b0;
    last_grant_d = last_grant_q;
    sb_ip_d      = sb_ip_q;
    out_port_d   = out_port_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    first_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          pop          = 1'b1;
          last_grant_d = grant_port;
          out_port_d   = grant_port;
          sb_ip_d      = mem_q[grant_port][rd_ptr_q[grant_port]];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sb_rd_req = 1'b1;
        first_d   = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        // Dropping the request with the last word stops the buffer from re-reading a head.
        sb_rd_req   = !bus.sb_packet_read_done;
        out_valid_d = 1'b1;
        out_sop_d   = first_q;
        out_eop_d   = bus.sb_packet_read_done;
        out_data_d  = bus.sb_odata;
        if (bus.sb_packet_read_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    empty_d  = '0;
    full_d   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      push_vec[p] = enq_fire && (bus.enq_port == port_t'(p));
      pop_vec[p]  = pop && (grant_port == port_t'(p));
      wr_ptr_d[p] = push_vec[p] ? wr_ptr_q[p] + ptr_t'(1) : wr_ptr_q[p];
      rd_ptr_d[p] = pop_vec[p]  ? rd_ptr_q[p] + ptr_t'(1) : rd_ptr_q[p];
      cnt_d[p]    = cnt_q[p] + cnt_t'(push_vec[p]) - cnt_t'(pop_vec[p]);
      empty_d[p]  = (cnt_d[p] == '0);
      full_d[p]   = (cnt_d[p] == cnt_t'(DEPTH));
    end
  end

  // NOTE: head storage has no reset; a slot is only read after the count shows it was written.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[bus.enq_port][wr_ptr_q[bus.enq_port]] <= bus.enq_addr;
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '{default: '0};
      rd_ptr_q     <= '{default: '0};
      cnt_q        <= '{default: '0};
      empty_q      <= '1;
      full_q       <= '0;
      last_grant_q <= port_t'(NUM_PORTS - 1);
      sb_ip_q      <= '0;
      out_port_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      last_grant_q <= last_grant_d;
      sb_ip_q      <= sb_ip_d;
      out_port_q   <= out_port_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      first_q      <= first_d;
    end
  end

  assign bus.enq_ready   = enq_ready;
  assign bus.sb_rd_req   = sb_rd_req;
  assign bus.sb_ip       = sb_ip_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_port    = out_port_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_sop     = out_sop_q;
  assign bus.out_eop     = out_eop_q;
  assign bus.queue_empty = empty_q;
  assign bus.queue_full  = full_q;
endmodule

// File: tb/tb_output_queue_scheduler.sv
// Bench for output_queue_scheduler: a linked-list shared-buffer model feeds packet words, and
// per-port FIFO queues of expected heads score every streamed packet.
module tb_output_queue_scheduler;
  localparam int NP = 4;
  localparam int PB = 2;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int QB = 4;

  typedef struct {
    logic [PB-1:0] port;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    int            cyc;
  } word_t;

  typedef struct {
    logic [AW-1:0] head;
    int            reqs;
    int            issue;
  } rd_t;

  logic clk;
  logic rst_n;

  output_queue_scheduler_if #(.NUM_PORTS(NP), .PORT_BITWIDTH(PB),
    .SHARED_BUFFER_ADDR_BITWIDTH(AW), .PACKET_DATA_BITWIDTH(DW)) bus ();

  output_queue_scheduler #(.NUM_PORTS(NP), .PORT_BITWIDTH(PB), .SHARED_BUFFER_ADDR_BITWIDTH(AW),
    .PACKET_DATA_BITWIDTH(DW), .QUEUE_DEPTH_BITWIDTH(QB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            eop_cnt  = 0;
  int            total_reqs = 0;
  int            next_addr  = 16;
  int            len_of [int];
  logic [AW-1:0] model_q [NP][$];
  word_t         words [$];
  rd_t           rd_log [$];

  // Shared-buffer model state
  logic          bm_active = 1'b0;
  logic          bm_pend   = 1'b0;
  logic [AW-1:0] bm_head;
  int            bm_idx, bm_len, bm_reqs, bm_issue;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] head, input int idx);
    return {16'hC0DE, 3'b000, head, idx[15:0], 16'h5A5A};
  endfunction

  function automatic logic [AW-1:0] new_addr();
    next_addr += 1 + $urandom_range(0, 3);
    return next_addr[AW-1:0];
  endfunction

  // Each read request returns one word of the chain one cycle later; the last word carries done.
  always @(posedge clk) begin
    if (!rst_n) begin
      bm_active = 1'b0;
      bm_pend   = 1'b0;
    end else if (bus.sb_rd_req) begin
      total_reqs++;
      if (!bm_active) begin
        bm_active = 1'b1;
        bm_head   = bus.sb_ip;
        bm_idx    = 0;
        bm_reqs   = 1;
        bm_issue  = cyc;
        bm_len    = len_of.exists(int'(bm_head)) ? len_of[int'(bm_head)] : 1;
      end else begin
        bm_idx++;
        bm_reqs++;
      end
      bm_pend = 1'b1;
    end else begin
      bm_pend = 1'b0;
    end
    cyc++;
    #1;
    if (bm_pend) begin
      bus.sb_odata            = word_of(bm_head, bm_idx);
      bus.sb_packet_read_done = (bm_idx == bm_len - 1);
      if (bm_idx == bm_len - 1) begin
        bm_active = 1'b0;
        rd_log.push_back('{bm_head, bm_reqs, bm_issue});
      end
    end else begin
      bus.sb_odata            = {$urandom(), $urandom()};
      bus.sb_packet_read_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      words.push_back('{bus.out_port, bus.out_data, bus.out_sop, bus.out_eop, cyc});
      if (bus.out_eop) eop_cnt++;
    end
  end

  task automatic enq_pkt(input int port, input logic [AW-1:0] addr, input int len);
    @(negedge clk);
    bus.enq_valid = 1'b1;
    bus.enq_port  = PB'(port);
    bus.enq_addr  = addr;
    len_of[int'(addr)] = len;
    model_q[port].push_back(addr);
  endtask

  task automatic enq_stop();
    @(negedge clk);
    bus.enq_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input int budget, input string tag);
    int k = 0;
    while (eop_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (eop_cnt < n) begin
      n_fail++;
      $display("FAIL %s_timeout: packets seen %0d, required %0d", tag, eop_cnt, n);
    end
  endtask

  // Splits the output log into packets and holds each against the per-port head FIFO.
  task automatic score_packets(input string tag, input int exp_pkts);
    int i = 0;
    int pkts = 0;
    int left = 0;
    while (i < words.size()) begin
      logic [AW-1:0] head;
      logic [AW-1:0] exp_head;
      int            port;
      int            len;
      head = words[i].data[44:32];
      port = int'(words[i].port);
      n_checks++;
      if (model_q[port].size() == 0) begin
        n_fail++;
        $display("FAIL %s_order: packet head %h on port %0d, required none", tag, head, port);
      end else begin
        exp_head = model_q[port].pop_front();
        if (head !== exp_head) begin
          n_fail++;
          $display("FAIL %s_order: port %0d head %h, required %h", tag, port, head, exp_head);
        end
      end
      len = len_of.exists(int'(head)) ? len_of[int'(head)] : 1;
      for (int k = 0; k < len && i < words.size(); k++) begin
        word_t w;
        w = words[i];
        n_checks++;
        if (w.data !== word_of(head, k) || int'(w.port) != port ||
            w.sop !== (k == 0) || w.eop !== (k == len - 1)) begin
          n_fail++;
          $display("FAIL %s_word: head %h word %0d got data %h port %0d sop %b eop %b, required data %h port %0d sop %b eop %b",
                   tag, head, k, w.data, w.port, w.sop, w.eop, word_of(head, k), port, k == 0, k == len - 1);
        end
        i++;
      end
      pkts++;
    end
    n_checks++;
    if (pkts != exp_pkts) begin
      n_fail++;
      $display("FAIL %s_count: packets %0d, required %0d", tag, pkts, exp_pkts);
    end
    foreach (rd_log[j]) begin
      n_checks++;
      if (!len_of.exists(int'(rd_log[j].head)) || rd_log[j].reqs != len_of[int'(rd_log[j].head)]) begin
        n_fail++;
        $display("FAIL %s_reqs: head %h read requests %0d, required %0d", tag, rd_log[j].head,
                 rd_log[j].reqs, len_of.exists(int'(rd_log[j].head)) ? len_of[int'(rd_log[j].head)] : -1);
      end
    end
    for (int p = 0; p < NP; p++) left += model_q[p].size();
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d expected packets never streamed, required 0", tag, left);
    end
    words.delete();
    rd_log.delete();
    eop_cnt = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.queue_empty !== 4'hF || bus.queue_full !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_flags: empty %b full %b, required 1111 0000", bus.queue_empty, bus.queue_full);
    end
    n_checks++;
    if (bus.sb_rd_req !== 1'b0 || bus.sb_ip !== '0) begin
      n_fail++;
      $display("FAIL reset_buffer: rd_req %b ip %h, required 0 0", bus.sb_rd_req, bus.sb_ip);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0 ||
        bus.out_port !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_output: valid %b sop %b eop %b port %0d data %h, required all 0",
               bus.out_valid, bus.out_sop, bus.out_eop, bus.out_port, bus.out_data);
    end
    n_checks++;
    if (bus.enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_enq_ready: %b, required 1", bus.enq_ready);
    end
  endtask

  task automatic test_round_robin();
    int exp_ports [4] = '{0, 2, 0, 2};
    int sops [$];
    bus.port_ready = 4'h0;
    for (int i = 0; i < 4; i++) enq_pkt(exp_ports[i], new_addr(), 1);
    enq_stop();
    bus.port_ready = 4'hF;
    wait_pkts(4, 100, "rr");
    foreach (words[i]) if (words[i].sop) sops.push_back(int'(words[i].port));
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= sops.size() || sops[i] != exp_ports[i]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: port %0d, required %0d", i, i < sops.size() ? sops[i] : -1, exp_ports[i]);
      end
    end
    // Back-to-back one-word packets issue every third cycle.
    for (int i = 1; i < rd_log.size(); i++) begin
      n_checks++;
      if (rd_log[i].issue - rd_log[i-1].issue != 3) begin
        n_fail++;
        $display("FAIL back_to_back_gap%0d: %0d cycles, required 3", i, rd_log[i].issue - rd_log[i-1].issue);
      end
    end
    score_packets("rr", 4);
  endtask

  task automatic test_single_packet();
    bus.port_ready = 4'hF;
    enq_pkt(1, 13'h005, 3);
    enq_stop();
    wait_pkts(1, 50, "single");
    n_checks++;
    if (rd_log.size() != 1 || rd_log[0].head !== 13'h005 || rd_log[0].reqs != 3) begin
      n_fail++;
      $display("FAIL single_read: reads %0d head %h reqs %0d, required 1 005 3", rd_log.size(),
               rd_log.size() > 0 ? rd_log[0].head : '0, rd_log.size() > 0 ? rd_log[0].reqs : 0);
    end
    n_checks++;
    if (words.size() != 3 || rd_log.size() != 1 ||
        words[0].cyc - rd_log[0].issue != 2 || words[words.size()-1].cyc - rd_log[0].issue != 4) begin
      n_fail++;
      $display("FAIL single_timing: %0d words, sop/eop at issue+%0d/+%0d, required 3 words at +2/+4",
               words.size(), words.size() > 0 && rd_log.size() > 0 ? words[0].cyc - rd_log[0].issue : -1,
               words.size() > 0 && rd_log.size() > 0 ? words[words.size()-1].cyc - rd_log[0].issue : -1);
    end
    score_packets("single", 1);
  endtask

  task automatic test_blocking();
    int r0;
    int c;
    bus.port_ready = 4'b0111;
    r0 = total_reqs;
    enq_pkt(3, new_addr(), 2);
    enq_stop();
    repeat (8) @(negedge clk);
    n_checks++;
    if (total_reqs != r0 || bus.queue_empty[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL block_hold: reads %0d empty3 %b, required 0 0", total_reqs - r0, bus.queue_empty[3]);
    end
    c = cyc;
    bus.port_ready = 4'hF;
    wait_pkts(1, 50, "block");
    n_checks++;
    if (rd_log.size() != 1 || rd_log[0].issue != c + 1) begin
      n_fail++;
      $display("FAIL block_release: issue cycle %0d, required %0d", rd_log.size() > 0 ? rd_log[0].issue : -1, c + 1);
    end
    score_packets("block", 1);
  endtask

  task automatic test_queue_full();
    logic [AW-1:0] extra;
    bus.port_ready = 4'h0;
    for (int i = 0; i < 16; i++) enq_pkt(2, new_addr(), int'($urandom_range(1, 3)));
    extra = new_addr();
    len_of[int'(extra)] = 1;
    @(negedge clk);
    bus.enq_valid = 1'b1;
    bus.enq_port  = 2'd2;
    bus.enq_addr  = extra;
    #1;
    n_checks++;
    if (bus.queue_full[2] !== 1'b1 || bus.enq_ready !== 1'b0 || bus.queue_empty[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: full2 %b enq_ready %b empty2 %b, required 1 0 0",
               bus.queue_full[2], bus.enq_ready, bus.queue_empty[2]);
    end
    @(negedge clk);
    bus.enq_valid = 1'b0;
    bus.enq_port  = 2'd1;
    #1;
    n_checks++;
    if (bus.enq_ready !== 1'b1 || bus.queue_full !== 4'b0100) begin
      n_fail++;
      $display("FAIL full_other: enq_ready %b full %b, required 1 0100", bus.enq_ready, bus.queue_full);
    end
    bus.port_ready = 4'hF;
    wait_pkts(16, 400, "full");
    score_packets("full", 16);
    n_checks++;
    if (bus.queue_empty !== 4'hF || bus.queue_full !== 4'h0) begin
      n_fail++;
      $display("FAIL full_drained: empty %b full %b, required 1111 0000", bus.queue_empty, bus.queue_full);
    end
  endtask

  task automatic test_concurrent();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 48; i++) begin
        enq_pkt(i % NP, new_addr(), 8);
        bus.port_ready = 4'($urandom_range(1, 15));
      end
      enq_stop();
      bus.port_ready = 4'hF;
      wait_pkts(48 * (ph + 1), 3000, "concurrent");
    end
    score_packets("concurrent", 96);
    n_checks++;
    if (bus.queue_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL concurrent_empty: %b, required 1111", bus.queue_empty);
    end
  endtask

  task automatic test_reset_midstream();
    int k = 0;
    logic pre;
    bus.port_ready = 4'hF;
    enq_pkt(0, new_addr(), 8);
    enq_stop();
    while (!bus.out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    pre = bus.sb_rd_req;
    n_checks++;
    if (!bus.out_valid || pre !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_stream: out_valid %b rd_req %b, required 1 1", bus.out_valid, pre);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.sb_rd_req !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: rd_req %b out_valid %b, required 0 0", bus.sb_rd_req, bus.out_valid);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.queue_empty !== 4'hF || bus.queue_full !== 4'h0 || bus.sb_ip !== '0) begin
      n_fail++;
      $display("FAIL midreset_release: empty %b full %b ip %h, required 1111 0000 0",
               bus.queue_empty, bus.queue_full, bus.sb_ip);
    end
    for (int p = 0; p < NP; p++) model_q[p].delete();
    words.delete();
    rd_log.delete();
    eop_cnt = 0;
  endtask

  initial begin
    rst_n                   = 1'b0;
    bus.enq_valid           = 1'b0;
    bus.enq_port            = '0;
    bus.enq_addr            = '0;
    bus.port_ready          = '0;
    bus.sb_odata            = '0;
    bus.sb_packet_read_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_round_robin();
    test_single_packet();
    test_blocking();
    test_queue_full();
    test_concurrent();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
